ifid_fetch_buffer: RTL and testbench

Fetch-to-decode buffer sitting directly downstream of the PC unit and instruction memory in the pipelined CPU. It captures each fetched instruction with its PC and PC+4, queues up to DEPTH entries, and presents the oldest to the decode stage over a valid/ready handshake. Every output is registered, so there is no combinational ready path back into fetch. A redirect flush from a taken branch, J, JAL or JR discards all wrong-path entries. Field slices for branchAddr/jumpAddr are driven directly for the decoder and PC unit.

---
 rtl/cpu_pipe_pkg.sv | 21 ++
 rtl/ifid_fetch_buffer_if.sv | 15 +
 rtl/ifid_fifo_mem.sv | 32 +++
 rtl/ifid_fetch_buffer.sv | 127 ++++++++++++
 tb/tb_ifid_fetch_buffer.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline definitions for the fetch/decode boundary: widths, instruction
// field positions and the entry type carried through the fetch buffer.
package cpu_pipe_pkg;

  localparam int INSTR_W   = 32;
  localparam int ADDR_W    = 32;

  localparam int OPC_MSB   = 31;
  localparam int OPC_LSB   = 26;
  localparam int IMM_MSB   = 15;
  localparam int JADDR_MSB = 25;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  pc_plus_four;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  localparam int ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/ifid_fetch_buffer_if.sv
// Valid/ready instruction stream carrying PC, PC+4 and the instruction word.
// The producer uses the master modport, the consumer the slave modport.
interface ifid_fetch_buffer_if;
  import cpu_pipe_pkg::*;

  logic               valid;
  logic               ready;
  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  pc_plus_four;
  logic [INSTR_W-1:0] instr;

  modport master (output valid, output pc, output pc_plus_four, output instr, input ready);
  modport slave  (input valid, input pc, input pc_plus_four, input instr, output ready);

endinterface

// File: rtl/ifid_fifo_mem.sv
// DEPTH-entry register array holding queued fetch entries; one write port and
// one combinational read port, cleared on reset.
module ifid_fifo_mem
  import cpu_pipe_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [PTR_W-1:0] wr_ptr,
  input  fetch_entry_t     wr_data,
  input  logic [PTR_W-1:0] rd_ptr,
  output fetch_entry_t     rd_data
);

  fetch_entry_t mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/ifid_fetch_buffer.sv
// Fetch-to-decode queue with fully registered outputs. The head entry lives in
// its own output register; the array behind it supplies the next head on a pop.
module ifid_fetch_buffer
  import cpu_pipe_pkg::*;
#(
  parameter int DEPTH       = 2,
  parameter int STALL_CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  ifid_fetch_buffer_if.slave       fetch,
  input  logic                     flush,
  ifid_fetch_buffer_if.master      id,
  output logic [5:0]               id_opcode,
  output logic [15:0]              id_branch_addr,
  output logic [25:0]              id_jump_addr,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [STALL_CNT_W-1:0]   stall_cycles
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]       wr_ptr_q;
  logic [PTR_W-1:0]       rd_ptr_q;
  logic [PTR_W-1:0]       rd_ptr_inc;
  logic [CNT_W-1:0]       count_q;
  logic [CNT_W-1:0]       count_next;
  logic                   fetch_ready_q;
  logic                   id_valid_q;
  logic [STALL_CNT_W-1:0] stall_q;
  fetch_entry_t           head_q;
  fetch_entry_t           head_next;
  fetch_entry_t           in_entry;
  fetch_entry_t           mem_rd_data;
  logic                   push;
  logic                   pop;
  logic                   wr_en;

  assign in_entry   = '{pc: fetch.pc, pc_plus_four: fetch.pc_plus_four, instr: fetch.instr};
  assign push       = fetch.valid & fetch_ready_q;
  assign pop        = id_valid_q & id.ready;
  assign wr_en      = push & ~flush;
  assign rd_ptr_inc = rd_ptr_q + 1'b1;

  // The array is always written on a push, even when that entry also goes
  // straight into the head register, so pointers and count stay in lockstep.
  ifid_fifo_mem #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_ptr  (wr_ptr_q),
    .wr_data (in_entry),
    .rd_ptr  (rd_ptr_inc),
    .rd_data (mem_rd_data)
  );

  // Next occupancy and the entry that will sit at the head after this edge;
  // with no entry left the head register keeps its last contents.
  always_comb begin
    count_next = count_q;
    head_next  = head_q;
    if (flush) begin
      count_next = '0;
    end else begin
      case ({push, pop})
        2'b10:   count_next = count_q + 1'b1;
        2'b01:   count_next = count_q - 1'b1;
        default: count_next = count_q;
      endcase
    end
    if (!flush && (count_next != '0)) begin
      if (pop) begin
        head_next = (count_q == CNT_W'(1)) ? in_entry : mem_rd_data;
      end else if (count_q == '0) begin
        head_next = in_entry;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      fetch_ready_q <= 1'b0;
      id_valid_q    <= 1'b0;
      head_q        <= '0;
    end else begin
      count_q       <= count_next;
      fetch_ready_q <= (count_next < CNT_W'(DEPTH));
      id_valid_q    <= (count_next != '0);
      head_q        <= head_next;
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  // Decode back-pressure counter; saturates and survives flushes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (id_valid_q && !id.ready && (stall_q != '1)) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign fetch.ready     = fetch_ready_q;
  assign id.valid        = id_valid_q;
  assign id.pc           = head_q.pc;
  assign id.pc_plus_four = head_q.pc_plus_four;
  assign id.instr        = head_q.instr;
  assign id_opcode       = head_q.instr[OPC_MSB:OPC_LSB];
  assign id_branch_addr  = head_q.instr[IMM_MSB:0];
  assign id_jump_addr    = head_q.instr[JADDR_MSB:0];
  assign occupancy       = count_q;
  assign stall_cycles    = stall_q;

endmodule

// File: tb/tb_ifid_fetch_buffer.sv
// Randomised bench for ifid_fetch_buffer against a queue-based reference model.
module tb_ifid_fetch_buffer;
  import cpu_pipe_pkg::*;

  localparam int DEPTH = 2;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic [5:0]  id_opcode;
  logic [15:0] id_branch_addr;
  logic [25:0] id_jump_addr;
  logic [1:0]  occupancy;
  logic [15:0] stall_cycles;

  ifid_fetch_buffer_if fetch_bus ();
  ifid_fetch_buffer_if id_bus ();

  ifid_fetch_buffer #(
    .DEPTH       (DEPTH),
    .STALL_CNT_W (16)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch          (fetch_bus),
    .flush          (flush),
    .id             (id_bus),
    .id_opcode      (id_opcode),
    .id_branch_addr (id_branch_addr),
    .id_jump_addr   (id_jump_addr),
    .occupancy      (occupancy),
    .stall_cycles   (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests;
  int errors;

  // Reference model: a plain queue of accepted entries
  fetch_entry_t q[$];
  logic         m_ready;
  logic         m_valid;
  fetch_entry_t m_head;
  int           m_stall;

  function automatic fetch_entry_t mk(input logic [31:0] pc);
    fetch_entry_t e;
    e.pc           = pc;
    e.pc_plus_four = pc + 32'd4;
    e.instr        = $urandom;
    return e;
  endfunction

  task automatic model_reset();
    q.delete();
    m_ready = 1'b0;
    m_valid = 1'b0;
    m_head  = '0;
    m_stall = 0;
  endtask

  // Drive one cycle of inputs, clock it, advance the model, land 1ns after the edge
  task automatic cycle(input logic fv, input fetch_entry_t e, input logic ir, input logic fl);
    logic push;
    logic pop;
    fetch_bus.valid        = fv;
    fetch_bus.pc           = e.pc;
    fetch_bus.pc_plus_four = e.pc_plus_four;
    fetch_bus.instr        = e.instr;
    id_bus.ready           = ir;
    flush                  = fl;
    push = fv && m_ready;
    pop  = m_valid && ir;
    if (m_valid && !ir && m_stall < 65535) m_stall++;
    @(posedge clk);
    if (fl) begin
      q.delete();
    end else begin
      if (pop)  void'(q.pop_front());
      if (push) q.push_back(e);
    end
    m_ready = (q.size() < DEPTH);
    m_valid = (q.size() > 0);
    if (m_valid) m_head = q[0];
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    fetch_bus.valid = 1'b0; fetch_bus.pc = '0; fetch_bus.pc_plus_four = '0; fetch_bus.instr = '0;
    id_bus.ready = 1'b0; flush = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    tests++; if (id_bus.valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_id_valid: got %b expected 0", id_bus.valid); end
    tests++; if (fetch_bus.ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_fetch_ready: got %b expected 0", fetch_bus.ready); end
    tests++; if (occupancy !== 2'd0) begin errors++; $display("[TB] FAIL reset_occupancy: got %0d expected 0", occupancy); end
    tests++; if (id_bus.instr !== 32'h0 || id_bus.pc !== 32'h0) begin errors++; $display("[TB] FAIL reset_id_data: got pc=%h instr=%h expected 0", id_bus.pc, id_bus.instr); end
    #3 rst_n = 1'b1;
    cycle(1'b0, '0, 1'b0, 1'b0);
    tests++; if (fetch_bus.ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_release_ready: got %b expected 1", fetch_bus.ready); end
  endtask

  task automatic test_single();
    fetch_entry_t e;
    e.pc = 32'h0040_0000; e.pc_plus_four = 32'h0040_0004; e.instr = 32'h1109_FFFE;
    cycle(1'b1, e, 1'b1, 1'b0);
    tests++; if (id_bus.valid !== 1'b1) begin errors++; $display("[TB] FAIL single_valid: got %b expected 1", id_bus.valid); end
    tests++; if (id_opcode !== 6'h04) begin errors++; $display("[TB] FAIL single_opcode: got %h expected 04", id_opcode); end
    tests++; if (id_branch_addr !== 16'hFFFE) begin errors++; $display("[TB] FAIL single_branch_addr: got %h expected fffe", id_branch_addr); end
    tests++; if (id_jump_addr !== 26'h109FFFE) begin errors++; $display("[TB] FAIL single_jump_addr: got %h expected 109fffe", id_jump_addr); end
    tests++; if (id_bus.pc !== 32'h0040_0000 || id_bus.pc_plus_four !== 32'h0040_0004) begin errors++; $display("[TB] FAIL single_pc: got %h/%h expected 00400000/00400004", id_bus.pc, id_bus.pc_plus_four); end
    cycle(1'b0, '0, 1'b1, 1'b0);
    tests++; if (id_bus.valid !== 1'b0) begin errors++; $display("[TB] FAIL single_pop_valid: got %b expected 0", id_bus.valid); end
    tests++; if (id_bus.pc !== 32'h0040_0000) begin errors++; $display("[TB] FAIL single_hold_pc: got %h expected 00400000", id_bus.pc); end
  endtask

  fetch_entry_t fill_e [3];

  task automatic test_fill();
    int stall0;
    for (int i = 0; i < 3; i++) fill_e[i] = mk(32'(i * 4));
    stall0 = int'(stall_cycles);
    cycle(1'b1, fill_e[0], 1'b0, 1'b0);
    tests++; if (fetch_bus.ready !== 1'b1 || occupancy !== 2'd1) begin errors++; $display("[TB] FAIL fill_first: got ready=%b occ=%0d expected ready=1 occ=1", fetch_bus.ready, occupancy); end
    cycle(1'b1, fill_e[1], 1'b0, 1'b0);
    tests++; if (fetch_bus.ready !== 1'b0) begin errors++; $display("[TB] FAIL fill_full_ready: got %b expected 0", fetch_bus.ready); end
    cycle(1'b1, fill_e[2], 1'b0, 1'b0);
    tests++; if (occupancy !== 2'd2) begin errors++; $display("[TB] FAIL fill_occupancy: got %0d expected 2", occupancy); end
    tests++; if (int'(stall_cycles) !== stall0 + 2 || int'(stall_cycles) !== m_stall) begin errors++; $display("[TB] FAIL fill_stall: got %0d expected %0d", stall_cycles, stall0 + 2); end
    tests++; if (id_bus.pc !== 32'h0 || id_bus.instr !== fill_e[0].instr) begin errors++; $display("[TB] FAIL fill_head: got pc=%h instr=%h expected pc=0 instr=%h", id_bus.pc, id_bus.instr, fill_e[0].instr); end
  endtask

  task automatic test_drain();
    cycle(1'b1, fill_e[2], 1'b1, 1'b0);
    tests++; if (id_bus.pc !== 32'h4 || id_bus.valid !== 1'b1) begin errors++; $display("[TB] FAIL drain_second: got pc=%h valid=%b expected pc=4 valid=1", id_bus.pc, id_bus.valid); end
    tests++; if (fetch_bus.ready !== 1'b1) begin errors++; $display("[TB] FAIL drain_ready: got %b expected 1", fetch_bus.ready); end
    cycle(1'b1, fill_e[2], 1'b1, 1'b0);
    tests++; if (id_bus.pc !== 32'h8 || id_bus.instr !== fill_e[2].instr || occupancy !== 2'd1) begin errors++; $display("[TB] FAIL drain_third: got pc=%h occ=%0d expected pc=8 occ=1", id_bus.pc, occupancy); end
    cycle(1'b0, '0, 1'b1, 1'b0);
    tests++; if (id_bus.valid !== 1'b0 || occupancy !== 2'd0) begin errors++; $display("[TB] FAIL drain_empty: got valid=%b occ=%0d expected 0/0", id_bus.valid, occupancy); end
  endtask

  task automatic test_stream();
    fetch_entry_t prev;
    fetch_entry_t e;
    for (int i = 0; i < 21; i++) begin
      e = mk(32'h1000 + 32'(i * 4));
      cycle(1'b1, e, 1'b1, 1'b0);
      tests++;
      if (id_bus.valid !== 1'b1 || occupancy !== 2'd1 || id_bus.instr !== e.instr || id_bus.pc !== e.pc) begin
        errors++;
        $display("[TB] FAIL stream_%0d: got valid=%b occ=%0d pc=%h instr=%h expected 1/1 pc=%h instr=%h",
                 i, id_bus.valid, occupancy, id_bus.pc, id_bus.instr, e.pc, e.instr);
      end
      if (i > 0 && prev.pc + 32'd4 !== e.pc) begin tests++; errors++; $display("[TB] FAIL stream_seq: got %h expected %h", e.pc, prev.pc + 32'd4); end
      prev = e;
    end
    cycle(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_flush();
    fetch_entry_t a;
    fetch_entry_t bad;
    a = mk(32'h2000);
    bad = mk(32'h3000);
    bad.instr = 32'h0810_0010;
    cycle(1'b1, a, 1'b0, 1'b0);
    cycle(1'b1, mk(32'h2004), 1'b0, 1'b0);
    cycle(1'b1, bad, 1'b0, 1'b1);
    tests++; if (id_bus.valid !== 1'b0 || occupancy !== 2'd0 || fetch_bus.ready !== 1'b1) begin errors++; $display("[TB] FAIL flush_full: got valid=%b occ=%0d ready=%b expected 0/0/1", id_bus.valid, occupancy, fetch_bus.ready); end
    cycle(1'b1, a, 1'b0, 1'b0);
    cycle(1'b1, bad, 1'b0, 1'b1);
    tests++; if (occupancy !== 2'd0 || id_bus.valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_push: got occ=%0d valid=%b expected 0/0", occupancy, id_bus.valid); end
    cycle(1'b0, '0, 1'b1, 1'b0);
    tests++; if (id_bus.instr === 32'h0810_0010 || id_bus.valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_leak: got instr=%h valid=%b expected not 08100010, valid 0", id_bus.instr, id_bus.valid); end
  endtask

  task automatic test_random();
    logic fv;
    logic ir;
    logic fl;
    for (int i = 0; i < 300; i++) begin
      fv = ($urandom_range(0, 3) != 0);
      ir = ($urandom_range(0, 2) != 0);
      fl = ($urandom_range(0, 19) == 0);
      cycle(fv, mk($urandom), ir, fl);
      tests++;
      if (id_bus.valid !== m_valid || fetch_bus.ready !== m_ready || occupancy !== 2'(q.size()) ||
          {id_bus.pc, id_bus.pc_plus_four, id_bus.instr} !== m_head || int'(stall_cycles) !== m_stall) begin
        errors++;
        $display("[TB] FAIL random_%0d: got v=%b r=%b occ=%0d pc=%h instr=%h stall=%0d expected v=%b r=%b occ=%0d pc=%h instr=%h stall=%0d",
                 i, id_bus.valid, fetch_bus.ready, occupancy, id_bus.pc, id_bus.instr, stall_cycles,
                 m_valid, m_ready, q.size(), m_head.pc, m_head.instr, m_stall);
      end
    end
  endtask

  task automatic test_async_reset();
    cycle(1'b1, mk(32'h4000), 1'b0, 1'b1);
    cycle(1'b1, mk(32'h4004), 1'b0, 1'b0);
    cycle(1'b1, mk(32'h4008), 1'b0, 1'b0);
    fetch_bus.valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    tests++; if (id_bus.valid !== 1'b0 || fetch_bus.ready !== 1'b0 || occupancy !== 2'd0) begin errors++; $display("[TB] FAIL async_ctrl: got valid=%b ready=%b occ=%0d expected 0/0/0", id_bus.valid, fetch_bus.ready, occupancy); end
    tests++; if (id_bus.pc !== 32'h0 || id_bus.instr !== 32'h0 || stall_cycles !== 16'h0) begin errors++; $display("[TB] FAIL async_data: got pc=%h instr=%h stall=%0d expected 0", id_bus.pc, id_bus.instr, stall_cycles); end
    model_reset();
    #2 rst_n = 1'b1;
    cycle(1'b0, '0, 1'b0, 1'b0);
    tests++; if (fetch_bus.ready !== 1'b1 || stall_cycles !== 16'h0) begin errors++; $display("[TB] FAIL async_release: got ready=%b stall=%0d expected 1/0", fetch_bus.ready, stall_cycles); end
  endtask

  task automatic test_saturation();
    cycle(1'b1, mk(32'h5000), 1'b0, 1'b0);
    for (int i = 0; i < 65540; i++) cycle(1'b0, '0, 1'b0, 1'b0);
    tests++; if (stall_cycles !== 16'hFFFF || m_stall != 65535) begin errors++; $display("[TB] FAIL stall_saturate: got %h expected ffff", stall_cycles); end
    cycle(1'b0, '0, 1'b0, 1'b1);
    tests++; if (stall_cycles !== 16'hFFFF || id_bus.valid !== 1'b0) begin errors++; $display("[TB] FAIL stall_after_flush: got stall=%h valid=%b expected ffff/0", stall_cycles, id_bus.valid); end
  endtask

  initial begin
    tests  = 0;
    errors = 0;
    test_reset();
    test_single();
    test_fill();
    test_drain();
    test_stream();
    test_flush();
    test_random();
    test_async_reset();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
